// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// Covers the FSM states, opcodes, datapath select codes, the legal R-type funct list and the control word.
package mc_pkg;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_IEXEC  = 4'd9;
   localparam logic [3:0] S_IWB    = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_HALT   = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;
   localparam logic [1:0] ALUOP_OR    = 2'd3;

   localparam logic [1:0] SRCB_RT    = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       extop;
      logic       instr_done;
   } ctrl_t;

   function automatic logic opcode_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic funct_legal(input logic [5:0] fn);
      case (fn)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait counter: counts consecutive not-ready cycles in a memory state and
// flags a timeout on the MEM_TIMEOUT-th one (ready on that cycle still succeeds).
module mc_mem_wait #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic mem_ready,
   output logic timeout
);

   logic [7:0] cnt_reg;
   logic [7:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (!waiting || mem_ready) begin
         cnt_next = 8'd0;
      end else begin
         cnt_next = cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= 8'd0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // cnt_reg holds the not-ready cycles already seen, so this fires on the limit cycle itself
   assign timeout = waiting & ~mem_ready & (cnt_reg == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM driving every datapath enable and select.
// MC_CTRL_ILLEGAL_TRAP_EN: trap illegal opcodes/functs to HALT and add the sticky illegal output.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       ExtOp,
   output logic       instr_done,
   output logic       mem_err,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   output logic       illegal,
`endif
   output logic [3:0] state
);

   logic [3:0] state_reg;
   logic [3:0] state_next;
   logic       mem_err_reg;
   logic       waiting;
   logic       timeout;
   logic       op_known;
   ctrl_t      c;

   // zero feeds the PC-write gate in the datapath, not this FSM
   logic zero_unused;
   assign zero_unused = zero;

   assign op_known = opcode_supported(opcode);
   assign waiting  = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic illegal_reg;
   logic trap;
   assign trap    = ~op_known | ((opcode == OP_RTYPE) & ~funct_legal(funct));
   assign illegal = rst_n & illegal_reg;
`else
   logic funct_unused;
   assign funct_unused = ^funct;
`endif

   mc_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
      .clk       (clk),
      .rst_n     (rst_n),
      .waiting   (waiting),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH: begin
            if (timeout)        state_next = S_HALT;
            else if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:    state_next = S_MEMADR;
               OP_RTYPE:        state_next = S_EXEC;
               OP_BEQ:          state_next = S_BRANCH;
               OP_ADDI, OP_ORI: state_next = S_IEXEC;
               OP_J:            state_next = S_JUMP;
               default:         state_next = S_FETCH;
            endcase
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (trap) state_next = S_HALT;
`endif
         end
         S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (timeout)        state_next = S_HALT;
            else if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWR: begin
            if (timeout)        state_next = S_HALT;
            else if (mem_ready) state_next = S_FETCH;
         end
         S_EXEC:  state_next = S_RWB;
         S_IEXEC: state_next = S_IWB;
         S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: state_next = S_FETCH;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   always_comb begin
      c = '0;
      case (state_reg)
         S_FETCH: begin
            c.memread = 1'b1;
            c.alusrcb = SRCB_FOUR;
            c.irwrite = mem_ready;
            c.pcwrite = mem_ready;
         end
         S_DECODE: begin
            c.alusrcb = SRCB_IMMSH;
            c.extop   = 1'b1;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
            c.instr_done = ~op_known;
`endif
         end
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
            c.extop   = 1'b1;
         end
         S_MEMRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWB: begin
            c.regwrite   = 1'b1;
            c.memtoreg   = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEMWR: begin
            c.memwrite   = 1'b1;
            c.iord       = 1'b1;
            c.instr_done = mem_ready;
         end
         S_EXEC: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_RT;
            c.aluop   = ALUOP_FUNCT;
         end
         S_RWB: begin
            c.regwrite   = 1'b1;
            c.regdst     = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca     = 1'b1;
            c.alusrcb     = SRCB_RT;
            c.aluop       = ALUOP_SUB;
            c.pcwritecond = 1'b1;
            c.pcsource    = PCSRC_ALUOUT;
            c.instr_done  = 1'b1;
         end
         S_IEXEC, S_IWB: begin
            // ALU controls and extension held through IWB so the result path stays stable
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
            if (opcode == OP_ORI) c.aluop = ALUOP_OR;
            else                  c.extop = 1'b1;
            if (state_reg == S_IWB) begin
               c.regwrite   = 1'b1;
               c.instr_done = 1'b1;
            end
         end
         S_JUMP: begin
            c.pcwrite    = 1'b1;
            c.pcsource   = PCSRC_JUMP;
            c.instr_done = 1'b1;
         end
         default: ;
      endcase
      if (!rst_n) c = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= S_FETCH;
         mem_err_reg <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         illegal_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         if (timeout) mem_err_reg <= 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         if ((state_reg == S_DECODE) && trap) illegal_reg <= 1'b1;
`endif
      end
   end

   assign PCWrite     = c.pcwrite;
   assign PCWriteCond = c.pcwritecond;
   assign IorD        = c.iord;
   assign MemRead     = c.memread;
   assign MemWrite    = c.memwrite;
   assign IRWrite     = c.irwrite;
   assign RegDst      = c.regdst;
   assign MemtoReg    = c.memtoreg;
   assign RegWrite    = c.regwrite;
   assign ALUSrcA     = c.alusrca;
   assign ALUSrcB     = c.alusrcb;
   assign ALUOp       = c.aluop;
   assign PCSource    = c.pcsource;
   assign ExtOp       = c.extop;
   assign instr_done  = c.instr_done;
   assign mem_err     = rst_n & mem_err_reg;
   assign state       = rst_n ? state_reg : 4'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus randomized instruction streams
// checked against an instruction-level model of the expected state walk and per-instruction totals.
module tb_mc_ctrl;
   import mc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp, instr_done, mem_err;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic       illegal;
`endif
   logic [31:0] all_outs;

   int checks   = 0;
   int failures = 0;

   localparam int TIMEOUT = 15;

   mc_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .PCSource    (PCSource),
      .ExtOp       (ExtOp),
      .instr_done  (instr_done),
      .mem_err     (mem_err),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      .illegal     (illegal),
`endif
      .state       (state)
   );

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign all_outs = 32'({illegal, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
                          MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp,
                          instr_done, mem_err, state});
`else
   assign all_outs = 32'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
                          MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp,
                          instr_done, mem_err, state});
`endif

   typedef struct {
      logic [3:0] st;
      logic       rdy;
   } step_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge; outputs are checked 1ns later.
   task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
      @(negedge clk);
      opcode    = op;
      funct     = fn;
      mem_ready = rdy;
      zero      = 1'($urandom);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rst_n     = 1'b0;
         mem_ready = 1'($urandom);
         opcode    = 6'($urandom);
         #1;
         chk("reset_outputs_zero", all_outs, 32'd0);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ready = 1'b0;
      opcode    = OP_RTYPE;
      #1;
      chk("post_reset_state", 32'(state), 32'(S_FETCH));
      chk("post_reset_memread", 32'(MemRead), 32'd1);
      chk("post_reset_mem_err", 32'(mem_err), 32'd0);
      $display("reset: pulse done, state=%0d MemRead=%0d", state, MemRead);
   endtask

   function automatic int reg_writes(input logic [5:0] op);
      case (op)
         OP_LW, OP_RTYPE, OP_ADDI, OP_ORI: return 1;
         default: return 0;
      endcase
   endfunction

   // Expected per-cycle state walk for one instruction, from the instruction's phases.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
      step_t q[$];
      int    regw = 0;
      int    irw  = 0;
      int    memw = 0;
      int    last;
      for (int i = 0; i < fw; i++) q.push_back('{S_FETCH, 1'b0});
      q.push_back('{S_FETCH, 1'b1});
      q.push_back('{S_DECODE, 1'($urandom)});
      case (op)
         OP_LW: begin
            q.push_back('{S_MEMADR, 1'($urandom)});
            for (int i = 0; i < mw; i++) q.push_back('{S_MEMRD, 1'b0});
            q.push_back('{S_MEMRD, 1'b1});
            q.push_back('{S_MEMWB, 1'($urandom)});
         end
         OP_SW: begin
            q.push_back('{S_MEMADR, 1'($urandom)});
            for (int i = 0; i < mw; i++) q.push_back('{S_MEMWR, 1'b0});
            q.push_back('{S_MEMWR, 1'b1});
         end
         OP_RTYPE: begin
            q.push_back('{S_EXEC, 1'($urandom)});
            q.push_back('{S_RWB, 1'($urandom)});
         end
         OP_BEQ:  q.push_back('{S_BRANCH, 1'($urandom)});
         OP_ADDI, OP_ORI: begin
            q.push_back('{S_IEXEC, 1'($urandom)});
            q.push_back('{S_IWB, 1'($urandom)});
         end
         OP_J:    q.push_back('{S_JUMP, 1'($urandom)});
         default: ;
      endcase
      last = q.size() - 1;
      foreach (q[i]) begin
         cyc(op, fn, q[i].rdy);
         chk("state", 32'(state), 32'(q[i].st));
         chk("instr_done", 32'(instr_done), 32'(i == last));
         chk("mem_err_clear", 32'(mem_err), 32'd0);
         regw += int'(RegWrite);
         irw  += int'(IRWrite);
         memw += int'(MemWrite);
         case (q[i].st)
            S_FETCH: begin
               chk("fetch_memread", 32'(MemRead), 32'd1);
               chk("fetch_irwrite", 32'(IRWrite), 32'(q[i].rdy));
               chk("fetch_pcwrite", 32'(PCWrite), 32'(q[i].rdy));
            end
            S_DECODE: begin
               chk("decode_alusrcb", 32'(ALUSrcB), 32'd3);
               chk("decode_extop", 32'(ExtOp), 32'd1);
            end
            S_MEMADR: chk("memadr_extop", 32'(ExtOp), 32'd1);
            S_MEMRD:  chk("memrd_iord", 32'({MemRead, IorD}), 32'b11);
            S_MEMWR:  chk("memwr_iord", 32'({MemWrite, IorD}), 32'b11);
            S_MEMWB:  chk("memwb_memtoreg", 32'({MemtoReg, RegDst}), 32'b10);
            S_EXEC:   chk("exec_aluop", 32'(ALUOp), 32'd2);
            S_RWB:    chk("rwb_regdst", 32'({RegDst, MemtoReg}), 32'b10);
            S_BRANCH: begin
               chk("branch_pcwritecond", 32'(PCWriteCond), 32'd1);
               chk("branch_pcsource", 32'(PCSource), 32'd1);
               chk("branch_aluop", 32'(ALUOp), 32'd1);
            end
            S_IEXEC, S_IWB: begin
               chk("imm_extop", 32'(ExtOp), 32'(op == OP_ADDI));
               chk("imm_aluop", 32'(ALUOp), (op == OP_ORI) ? 32'd3 : 32'd0);
            end
            S_JUMP: begin
               chk("jump_pcwrite", 32'(PCWrite), 32'd1);
               chk("jump_pcsource", 32'(PCSource), 32'd2);
            end
            default: ;
         endcase
      end
      chk("regwrite_count", 32'(regw), 32'(reg_writes(op)));
      chk("irwrite_count", 32'(irw), 32'd1);
      chk("memwrite_cycles", 32'(memw), (op == OP_SW) ? 32'(mw + 1) : 32'd0);
      $display("instr: op=0x%02h funct=0x%02h fetch_wait=%0d mem_wait=%0d cycles=%0d regwrites=%0d",
               op, fn, fw, mw, q.size(), regw);
   endtask

   logic [5:0] op_tab [0:8];
   logic [5:0] fn_tab [0:4];

   initial begin
      rst_n     = 1'b0;
      opcode    = OP_RTYPE;
      funct     = FN_ADD;
      zero      = 1'b0;
      mem_ready = 1'b0;
      op_tab    = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J, 6'h3F, 6'h10};
      fn_tab    = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

      do_reset();

      run_instr(OP_ORI, FN_ADD, 0, 0);
      run_instr(OP_ADDI, FN_ADD, 0, 0);
      run_instr(OP_LW, FN_ADD, 0, 3);
      run_instr(OP_BEQ, FN_ADD, 0, 0);
      run_instr(OP_J, FN_ADD, 0, 0);
      run_instr(OP_RTYPE, FN_SLT, 2, 0);
      // ready arriving on the limit cycle is still a success
      run_instr(OP_LW, FN_ADD, 0, TIMEOUT - 1);
      run_instr(OP_SW, FN_ADD, TIMEOUT - 1, TIMEOUT - 1);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      cyc(6'h3F, FN_ADD, 1'b1);
      cyc(6'h3F, FN_ADD, 1'b1);
      chk("illegal_decode_done", 32'(instr_done), 32'd0);
      cyc(6'h3F, FN_ADD, 1'b0);
      chk("illegal_op_halt", 32'(state), 32'(S_HALT));
      chk("illegal_op_flag", 32'(illegal), 32'd1);
      $display("trap: opcode=0x3f state=%0d illegal=%0d", state, illegal);
      do_reset();
      cyc(OP_RTYPE, 6'h3F, 1'b1);
      cyc(OP_RTYPE, 6'h3F, 1'b1);
      cyc(OP_RTYPE, 6'h3F, 1'b1);
      chk("illegal_funct_halt", 32'(state), 32'(S_HALT));
      chk("illegal_funct_flag", 32'(illegal), 32'd1);
      $display("trap: rtype funct=0x3f state=%0d illegal=%0d", state, illegal);
      do_reset();
`else
      run_instr(6'h3F, FN_ADD, 0, 0);
      run_instr(OP_RTYPE, 6'h3F, 0, 0);
`endif

      // reset while an lw waits in MEMRD: no write may leak out
      cyc(OP_LW, FN_ADD, 1'b1);
      cyc(OP_LW, FN_ADD, 1'b0);
      cyc(OP_LW, FN_ADD, 1'b0);
      cyc(OP_LW, FN_ADD, 1'b0);
      chk("abort_in_memrd", 32'(state), 32'(S_MEMRD));
      do_reset();

      for (int n = 0; n < 40; n++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         run_instr(op_tab[$urandom_range(0, 6)], fn_tab[$urandom_range(0, 4)],
                   $urandom_range(0, 5), $urandom_range(0, 5));
`else
         run_instr(op_tab[$urandom_range(0, 8)], fn_tab[$urandom_range(0, 4)],
                   $urandom_range(0, 5), $urandom_range(0, 5));
`endif
      end

      // sw that never sees mem_ready
      cyc(OP_SW, FN_ADD, 1'b1);
      cyc(OP_SW, FN_ADD, 1'b0);
      cyc(OP_SW, FN_ADD, 1'b0);
      for (int k = 1; k <= TIMEOUT; k++) begin
         cyc(OP_SW, FN_ADD, 1'b0);
         chk("timeout_wait_state", 32'(state), 32'(S_MEMWR));
         chk("timeout_wait_err", 32'(mem_err), 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         cyc(OP_SW, FN_ADD, 1'($urandom));
         chk("timeout_halt_state", 32'(state), 32'(S_HALT));
         chk("timeout_mem_err", 32'(mem_err), 32'd1);
         chk("timeout_halt_outs", all_outs & 32'hFFFF_FFE0, 32'd0);
      end
      $display("timeout: state=%0d mem_err=%0d", state, mem_err);
      do_reset();
      run_instr(OP_LW, FN_ADD, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
